// File: rtl/pipeline_pkg.sv
// Shared LEGv8 pipeline types: EX/MEM and MEM/WB bundles, memory-stage FSM encoding
// and the access-legality helpers used by the memory stage.
package pipeline_pkg;
    localparam int DATA_W = 64;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] branch_addr;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic              zero;
        logic              b;
        logic              bz;
        logic              bnz;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_W-1:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
    } mem_wb_t;

    // A legal access names exactly one direction and a doubleword-aligned address.
    function automatic logic mem_legal(input logic valid, input logic rd_en,
                                       input logic wr_en, input logic [2:0] addr_lo);
        return valid & (rd_en ^ wr_en) & (addr_lo == 3'b000);
    endfunction

    function automatic logic mem_fault(input logic valid, input logic rd_en,
                                       input logic wr_en, input logic [2:0] addr_lo);
        return valid & (rd_en | wr_en) & ~((rd_en ^ wr_en) & (addr_lo == 3'b000));
    endfunction
endpackage

// File: rtl/branch_resolve.sv
// Branch decision from the registered EX/MEM bundle: unconditional, CBZ and CBNZ.
module branch_resolve
    import pipeline_pkg::*;
(
    input  logic              valid,
    input  logic              b,
    input  logic              bz,
    input  logic              bnz,
    input  logic              zero,
    input  logic [DATA_W-1:0] branch_addr,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target
);
    assign pc_src        = valid & (b | (bz & zero) | (bnz & ~zero));
    assign branch_target = branch_addr;
endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus data-memory access stage: resolves branches, runs
// LDUR/STUR over a req/ack port with a timeout, and stalls upstream while waiting.
module mem_access_stage #(
    parameter int DATA_W  = pipeline_pkg::DATA_W,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_branch_addr,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_zero,
    input  logic              ex_b,
    input  logic              ex_bz,
    input  logic              ex_bnz,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_rd,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_read_data,
    output logic              mem_error
);
    import pipeline_pkg::*;

    ex_mem_t          ex_bundle;
    ex_mem_t          exmem_d, exmem_q;
    mem_wb_t          wb_d, wb_q;
    mem_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             mem_error_d, mem_error_q;
    logic             in_access;
    logic             timeout_hit;
    logic             start_access;
    logic             fault_q;

    assign ex_bundle = '{
        valid:       ex_valid,
        branch_addr: ex_branch_addr,
        alu_result:  ex_alu_result,
        store_data:  ex_store_data,
        zero:        ex_zero,
        b:           ex_b,
        bz:          ex_bz,
        bnz:         ex_bnz,
        mem_read:    ex_mem_read,
        mem_write:   ex_mem_write,
        mem_to_reg:  ex_mem_to_reg,
        reg_write:   ex_reg_write,
        rd:          ex_rd
    };

    assign in_access    = (state_q == ACCESS);
    assign timeout_hit  = in_access & ~dmem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
    assign stall        = in_access & ~dmem_ack & ~timeout_hit;
    assign start_access = mem_legal(ex_valid, ex_mem_read, ex_mem_write, ex_alu_result[2:0]);
    assign fault_q      = mem_fault(exmem_q.valid, exmem_q.mem_read, exmem_q.mem_write,
                                    exmem_q.alu_result[2:0]);

    // Stall is combinational, so the next bundle is captured on the edge an access ends.
    always_comb begin
        exmem_d = exmem_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            exmem_d = ex_bundle;
            state_d = start_access ? ACCESS : IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        wb_d        = '0;
        mem_error_d = mem_error_q;
        if (in_access) begin
            if (dmem_ack || timeout_hit) begin
                wb_d.valid      = 1'b1;
                wb_d.mem_to_reg = exmem_q.mem_to_reg;
                wb_d.rd         = exmem_q.rd;
                wb_d.alu_result = exmem_q.alu_result;
                if (dmem_ack) begin
                    wb_d.reg_write = exmem_q.reg_write & exmem_q.mem_read;
                    wb_d.read_data = exmem_q.mem_read ? dmem_rdata : '0;
                end else begin
                    mem_error_d = 1'b1;
                end
            end
        end else begin
            // In IDLE the register only ever holds a bubble, a non-memory op or a faulting access.
            wb_d.valid      = exmem_q.valid;
            wb_d.mem_to_reg = exmem_q.mem_to_reg;
            wb_d.rd         = exmem_q.rd;
            wb_d.alu_result = exmem_q.alu_result;
            wb_d.reg_write  = exmem_q.valid & exmem_q.reg_write
                            & ~exmem_q.mem_read & ~exmem_q.mem_write;
            if (fault_q) begin
                mem_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            wb_q        <= '0;
            mem_error_q <= 1'b0;
        end else begin
            exmem_q     <= exmem_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_q        <= wb_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign dmem_req   = in_access;
    assign dmem_we    = in_access & exmem_q.mem_write;
    assign dmem_addr  = in_access ? exmem_q.alu_result : '0;
    assign dmem_wdata = in_access ? exmem_q.store_data : '0;

    branch_resolve u_branch_resolve (
        .valid         (exmem_q.valid),
        .b             (exmem_q.b),
        .bz            (exmem_q.bz),
        .bnz           (exmem_q.bnz),
        .zero          (exmem_q.zero),
        .branch_addr   (exmem_q.branch_addr),
        .pc_src        (pc_src),
        .branch_target (branch_target)
    );

    assign wb_valid      = wb_q.valid;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_rd         = wb_q.rd;
    assign wb_alu_result = wb_q.alu_result;
    assign wb_read_data  = wb_q.read_data;
    assign mem_error     = mem_error_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a transaction-level
// reference model; a short directed prologue precedes the random stream.
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    typedef struct {
        logic        valid;
        logic [63:0] branch_addr;
        logic [63:0] alu_result;
        logic [63:0] store_data;
        logic        zero;
        logic        b;
        logic        bz;
        logic        bnz;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd;
        int          delay;
        logic [63:0] rdata;
        bit          reset_mid;
    } op_t;

    logic        clk, reset;
    logic        ex_valid, ex_zero, ex_b, ex_bz, ex_bnz;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic [63:0] ex_branch_addr, ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        stall, pc_src, dmem_req, dmem_we, dmem_ack;
    logic [63:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, mem_error;
    logic [4:0]  wb_rd;
    logic [63:0] wb_alu_result, wb_read_data;

    mem_access_stage #(.DATA_W(64), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_branch_addr(ex_branch_addr), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_zero(ex_zero), .ex_b(ex_b), .ex_bz(ex_bz),
        .ex_bnz(ex_bnz), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
        .mem_error(mem_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int  n_checks = 0;
    int  n_fail   = 0;
    op_t cur, ex_op;
    bit  in_mem, need_new, exp_err;
    int  n;
    op_t directed[$];

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t blank_op();
        op_t o;
        o = '{default: 0};
        return o;
    endfunction

    function automatic bit is_legal_mem(op_t o);
        return o.valid && (o.mem_read != o.mem_write) && (o.alu_result[2:0] == 3'd0);
    endfunction

    function automatic bit is_fault(op_t o);
        return o.valid && (o.mem_read || o.mem_write) && !is_legal_mem(o);
    endfunction

    function automatic bit is_taken(op_t o);
        return o.valid && (o.b || (o.bz && o.zero) || (o.bnz && !o.zero));
    endfunction

    function automatic op_t mk_alu(input logic [63:0] alu, input logic [4:0] rd);
        op_t o = blank_op();
        o.valid = 1'b1; o.alu_result = alu; o.rd = rd; o.reg_write = 1'b1;
        return o;
    endfunction

    function automatic op_t mk_br(input logic b, input logic bz, input logic bnz,
                                  input logic zero, input logic [63:0] addr);
        op_t o = blank_op();
        o.valid = 1'b1; o.b = b; o.bz = bz; o.bnz = bnz; o.zero = zero; o.branch_addr = addr;
        return o;
    endfunction

    function automatic op_t mk_mem(input logic rd_en, input logic wr_en, input logic [63:0] addr,
                                   input int delay, input logic [63:0] rdata);
        op_t o = blank_op();
        o.valid = 1'b1; o.mem_read = rd_en; o.mem_write = wr_en; o.alu_result = addr;
        o.mem_to_reg = rd_en; o.reg_write = 1'b1; o.rd = 5'd9; o.delay = delay;
        o.rdata = rdata; o.store_data = 64'h1234_5678_9ABC_DEF0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o = blank_op();
        int unsigned kind = $urandom_range(0, 9);
        o.valid       = 1'b1;
        o.rd          = 5'($urandom);
        o.alu_result  = {$urandom, $urandom};
        o.branch_addr = {$urandom, $urandom};
        o.store_data  = {$urandom, $urandom};
        o.rdata       = {$urandom, $urandom};
        o.zero        = 1'($urandom);
        o.mem_to_reg  = 1'($urandom);
        o.reg_write   = 1'($urandom);
        o.delay       = int'($urandom_range(1, 5));
        case (kind)
            2: case ($urandom_range(0, 2))
                   0:       o.b   = 1'b1;
                   1:       o.bz  = 1'b1;
                   default: o.bnz = 1'b1;
               endcase
            3, 4: begin o.mem_read = 1'b1; o.mem_to_reg = 1'b1; o.alu_result[2:0] = 3'd0; end
            5: begin o.mem_write = 1'b1; o.alu_result[2:0] = 3'd0; end
            6: begin
                o.mem_read = 1'($urandom);
                o.mem_write = !o.mem_read;
                o.alu_result[2:0] = 3'($urandom_range(1, 7));
            end
            7: begin o.mem_read = 1'b1; o.mem_write = 1'b1; end
            8: begin
                o.valid = 1'b0; o.mem_read = 1'($urandom); o.mem_write = 1'($urandom);
                o.b = 1'($urandom); o.alu_result[2:0] = 3'd0;
            end
            9: begin
                o.mem_read = 1'($urandom);
                o.mem_write = !o.mem_read;
                o.alu_result[2:0] = 3'd0;
                case ($urandom_range(0, 2))
                    0:       o.delay = 10;
                    1:       o.delay = TIMEOUT;
                    default: o.delay = NEVER;
                endcase
                o.reset_mid = ($urandom_range(0, 2) == 0);
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic apply_stimulus(input op_t o);
        ex_valid = o.valid; ex_branch_addr = o.branch_addr; ex_alu_result = o.alu_result;
        ex_store_data = o.store_data; ex_zero = o.zero; ex_b = o.b; ex_bz = o.bz;
        ex_bnz = o.bnz; ex_mem_read = o.mem_read; ex_mem_write = o.mem_write;
        ex_mem_to_reg = o.mem_to_reg; ex_reg_write = o.reg_write; ex_rd = o.rd;
    endtask

    // One clock of the reference model: respond on the memory port, check, then retire.
    task automatic run_cycle();
        bit          ack_now, finish, exp_stall, exp_valid, exp_rw, m2r_chk;
        logic [63:0] exp_rdata;
        op_t         done;
        @(negedge clk);
        if (in_mem && n == 2 && cur.reset_mid) begin
            reset = 1'b1;
            #1;
            check_output("reset_dmem_req", 64'(dmem_req), 64'd0);
            check_output("reset_stall", 64'(stall), 64'd0);
            check_output("reset_wb_valid", 64'(wb_valid), 64'd0);
            check_output("reset_wb_alu", wb_alu_result, 64'd0);
            check_output("reset_mem_error", 64'(mem_error), 64'd0);
            reset = 1'b0;
            cur = blank_op(); in_mem = 1'b0; n = 0; exp_err = 1'b0;
            ack_now = 1'b0;
            dmem_ack = 1'b1;
            dmem_rdata = {$urandom, $urandom};
        end else begin
            ack_now = in_mem && (n == cur.delay);
            dmem_ack = in_mem ? ack_now : ($urandom_range(0, 5) == 0);
            dmem_rdata = ack_now ? cur.rdata : {$urandom, $urandom};
        end
        if (need_new) begin
            if (directed.size() > 0) ex_op = directed.pop_front();
            else ex_op = rand_op();
            apply_stimulus(ex_op);
        end
        #1;
        finish    = in_mem && (ack_now || n == TIMEOUT);
        exp_stall = in_mem && !finish;
        check_output("stall", 64'(stall), 64'(exp_stall));
        check_output("pc_src", 64'(pc_src), 64'(is_taken(cur)));
        check_output("branch_target", branch_target, cur.branch_addr);
        check_output("dmem_req", 64'(dmem_req), 64'(in_mem));
        if (in_mem) begin
            check_output("dmem_we", 64'(dmem_we), 64'(cur.mem_write));
            check_output("dmem_addr", dmem_addr, cur.alu_result);
            check_output("dmem_wdata", dmem_wdata, cur.store_data);
        end

        @(posedge clk);
        done = cur;
        exp_valid = 1'b0; exp_rw = 1'b0; exp_rdata = 64'd0; m2r_chk = 1'b0;
        if (in_mem) begin
            if (finish) begin
                exp_valid = 1'b1;
                if (ack_now) begin
                    exp_rw    = cur.reg_write && cur.mem_read;
                    exp_rdata = cur.mem_read ? cur.rdata : 64'd0;
                    m2r_chk   = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else begin
            exp_valid = cur.valid;
            if (is_fault(cur)) exp_err = 1'b1;
            else begin
                exp_rw  = cur.valid && cur.reg_write;
                m2r_chk = cur.valid;
            end
        end
        if (!exp_stall) begin
            cur = ex_op; in_mem = is_legal_mem(ex_op); n = 1;
        end else begin
            n++;
        end
        need_new = !exp_stall;
        #1;
        check_output("wb_valid", 64'(wb_valid), 64'(exp_valid));
        if (exp_valid) begin
            check_output("wb_reg_write", 64'(wb_reg_write), 64'(exp_rw));
            check_output("wb_rd", 64'(wb_rd), 64'(done.rd));
            check_output("wb_alu_result", wb_alu_result, done.alu_result);
            check_output("wb_read_data", wb_read_data, exp_rdata);
            if (m2r_chk) check_output("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(done.mem_to_reg));
        end
        check_output("mem_error", 64'(mem_error), 64'(exp_err));
    endtask

    initial begin
        op_t tmp;
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 64'd0;
        apply_stimulus(blank_op());
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_stall", 64'(stall), 64'd0);
        check_output("rst_dmem_req", 64'(dmem_req), 64'd0);
        check_output("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_output("rst_mem_error", 64'(mem_error), 64'd0);
        check_output("rst_pc_src", 64'(pc_src), 64'd0);
        check_output("rst_branch_target", branch_target, 64'd0);
        reset = 1'b0;

        cur = blank_op(); ex_op = blank_op();
        in_mem = 1'b0; need_new = 1'b1; exp_err = 1'b0; n = 0;

        directed.push_back(mk_alu(64'h2A, 5'd5));
        directed.push_back(mk_br(1'b0, 1'b1, 1'b0, 1'b1, 64'h100));
        directed.push_back(mk_br(1'b0, 1'b1, 1'b0, 1'b0, 64'h100));
        directed.push_back(mk_br(1'b0, 1'b0, 1'b1, 1'b0, 64'h200));
        directed.push_back(mk_mem(1'b1, 1'b0, 64'h40, 3, 64'hDEAD_BEEF));
        directed.push_back(mk_mem(1'b0, 1'b1, 64'h43, 1, 64'd0));
        directed.push_back(mk_mem(1'b1, 1'b1, 64'h48, 1, 64'd0));
        directed.push_back(mk_mem(1'b1, 1'b0, 64'h80, NEVER, 64'h55));
        tmp = mk_mem(1'b1, 1'b0, 64'h88, 10, 64'h77);
        tmp.reset_mid = 1'b1;
        directed.push_back(tmp);
        directed.push_back(mk_alu(64'h2A, 5'd5));
        directed.push_back(mk_mem(1'b1, 1'b0, 64'h90, TIMEOUT, 64'hCAFE_F00D));
        directed.push_back(mk_mem(1'b0, 1'b1, 64'h98, 2, 64'd0));
        directed.push_back(mk_mem(1'b1, 1'b0, 64'hA0, 1, 64'h0123_4567_89AB_CDEF));
        directed.push_back(mk_alu(64'h99, 5'd3));

        for (int cyc = 0; cyc < 2500; cyc++) begin
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Registered EX/MEM boundary plus memory-access stage of the 64-bit LEGv8 pipeline.
- It sits directly downstream of the execution stage. It captures that stage's ALU result, branch target, store data, zero flag and control bits.
- It resolves branches (PCSrc) and runs LDUR/STUR through a request/acknowledge data-memory port, stalling upstream while waiting.
- It presents a registered bundle to write-back.

Parameters:
DATA_W, 64, width of ALU result, store data, load data and addresses
TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting an access
CNT_W, 5, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  execution-stage bundle is a real instruction (0 = bubble)
ex_branch_addr  in  DATA_W  computed branch target
ex_alu_result  in  DATA_W  ALU result / memory address
ex_store_data  in  DATA_W  Data2 operand for STUR
ex_zero  in  1  ALU zero flag
ex_b, ex_bz, ex_bnz  in  1 each  unconditional / CBZ / CBNZ
ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  in  1 each  control
ex_rd  in  5  destination register (Instruction[4:0])
stall  out  1  upstream must hold its bundle this cycle
pc_src  out  1  take branch
branch_target  out  DATA_W  target when pc_src=1
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = store
dmem_addr  out  DATA_W  byte address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, valid with ack
dmem_ack  in  1  access complete
wb_valid, wb_reg_write, wb_mem_to_reg  out  1 each  write-back controls
wb_rd  out  5  write-back register
wb_alu_result, wb_read_data  out  DATA_W  write-back operands
mem_error  out  1  sticky fault flag (misaligned, illegal, timeout)

Behaviour:
- Reset (async, immediate): every output, the EX/MEM register and the FSM go to 0/IDLE. mem_error clears only on reset.
- EX/MEM register: loads the full ex_* bundle on each edge where stall=0. A bubble (ex_valid=0) loads valid_q=0.
- pc_src = valid_q & (b_q | (bz_q & zero_q) | (bnz_q & ~zero_q)). branch_target = branch_addr_q. Both are combinational from the register, so they are high for exactly one cycle per branch.
- FSM states:
  - IDLE: register holds a non-memory op or a bubble.
  - ACCESS: request outstanding.
- Transitions:
  - Capture of a valid op with exactly one of mem_read/mem_write set, and addr[2:0]==0 -> ACCESS.
  - ACCESS & dmem_ack -> IDLE.
  - ACCESS & counter==TIMEOUT-1 & !ack -> IDLE with timeout fault.
- In ACCESS:
  - dmem_req=1; dmem_we=mem_write_q; dmem_addr=alu_result_q; dmem_wdata=store_data_q, all stable.
  - The counter increments each cycle and is zeroed on entry.
- stall = (state==ACCESS) & ~dmem_ack & ~timeout_hit. It is combinational, so a new bundle is captured on the same edge the access completes.
- WB bundle (registered):
  - Non-memory op: updated on the edge after capture (1-cycle latency).
  - Memory op: updated on the ack/timeout edge; wb_read_data = dmem_rdata on a load, 0 on a timeout.
  - While stalled: wb_valid=0.
- Faults set mem_error and produce wb_valid=1 with wb_reg_write=0. No memory request is issued for these faults:
  - misaligned address (addr[2:0]!=0) with mem_read or mem_write;
  - both mem_read and mem_write set.
- Timeout sets mem_error and suppresses the load's reg_write. A store is dropped.
- Reset during ACCESS: dmem_req drops immediately, and a later ack is ignored (IDLE ignores dmem_ack).
- Ack in IDLE is ignored.
- Store: wb_reg_write=0 regardless of ex_reg_write.

Decomposition:
- Shared package pipeline_pkg holds:
  - DATA_W;
  - the FSM state encoding (IDLE=1'b0, ACCESS=1'b1);
  - a typedef for the EX/MEM bundle, reused by the execution stage's output;
  - a typedef for the MEM/WB bundle, reused by write-back.
- One natural sub-module, branch_resolve: combinational pc_src/branch_target from the registered bundle. Everything else stays inline.

Test Plan:
- ADD bundle, alu_result=0x2A, rd=5, reg_write=1 -> next edge: wb_valid=1, wb_alu_result=0x2A, wb_rd=5, stall never high.
- CBZ with zero=1, branch_addr=0x100 -> pc_src=1 and branch_target=0x100 for exactly one cycle. The same with zero=0 -> pc_src=0. CBNZ with zero=0 -> pc_src=1.
- LDUR addr=0x40, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req high for 3 cycles, stall high for 2 cycles, wb_read_data=0xDEADBEEF, wb_mem_to_reg=1.
- STUR addr=0x43 -> no dmem_req, mem_error=1, wb_reg_write=0. STUR with both read and write set -> same response.
- LDUR with ack withheld -> req for TIMEOUT=16 cycles, then IDLE, mem_error=1, wb_reg_write=0, wb_read_data=0.
- Assert reset mid-ACCESS, then ack one cycle later -> dmem_req=0 at once, all outputs 0, late ack ignored, next ADD completes normally.
